// File: rtl/rr_mux16_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : rr_mux16_arbiter
//  Purpose  : Round-robin arbiter/sequencer in front of a shared 16:1 W-bit
//             mux. It picks one of sixteen requesters, drives the mux select,
//             registers the selected lane and holds it on a valid/ready
//             output until the consumer accepts it.
//  Ports    : clk       - system clock, rising edge
//             rst       - synchronous active-high reset
//             req[15:0] - request lines, bit i = requester i has data
//             inp       - 16 flattened W-bit lanes, lane i = inp[i*W +: W]
//             out_ready - consumer accepts out_data when high with out_valid
//             gnt[15:0] - one-hot grant, zero when nothing is granted
//             sel[3:0]  - mux select (index of granted requester)
//             out_data  - registered copy of the granted lane
//             out_valid - out_data holds an unaccepted item
//  Options  : ARB_B2B_EN - when defined, a handshake may re-grant another
//             pending requester on the same edge (one item per cycle).
//             Undefined: every handshake returns to IDLE for one cycle.
//  Revision : 1.0 - initial release
// ============================================================================
module rr_mux16_arbiter #(
  parameter int W = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [15:0]     req,
  input  logic [16*W-1:0] inp,
  input  logic            out_ready,
  output logic [15:0]     gnt,
  output logic [3:0]      sel,
  output logic [W-1:0]    out_data,
  output logic            out_valid
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] HOLD = 1'b1;

  logic [0:0]   state;
  logic [3:0]   ptr;        // index of the last requester served
  logic [W-1:0] lane [16];

  // Unflatten the input bus into an indexable lane array.
  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_lane
      assign lane[gi] = inp[gi*W +: W];
    end
  endgenerate

  // Round-robin scan: first set bit of r starting at start+1, wrapping, with
  // start itself checked last. Iterating from the farthest offset down lets
  // the nearest hit overwrite the result without an early exit.
  // Returns {found, index}.
  function automatic logic [4:0] scan(input logic [15:0] r,
                                      input logic [3:0]  start);
    logic [4:0] res;
    logic [3:0] idx;
    res = 5'd0;
    for (int k = 16; k >= 1; k--) begin
      idx = start + 4'(k);
      if (r[idx]) begin
        res = {1'b1, idx};
      end
    end
    return res;
  endfunction

  logic [4:0] idle_pick;
  logic       release_item;
  logic       grant_en;
  logic [3:0] grant_idx;

`ifdef ARB_B2B_EN
  logic [4:0] next_pick;
`endif

  always_comb begin
    idle_pick    = scan(req, ptr);
    release_item = (state == HOLD) && out_ready;
    grant_en     = 1'b0;
    grant_idx    = 4'd0;
`ifdef ARB_B2B_EN
    // Exclude the requester being served right now; gnt is one-hot at sel
    // while in HOLD, so it doubles as the mask.
    next_pick    = scan(req & ~gnt, sel);
`endif
    if (state == IDLE) begin
      grant_en  = idle_pick[4];
      grant_idx = idle_pick[3:0];
    end
`ifdef ARB_B2B_EN
    else if (release_item) begin
      grant_en  = next_pick[4];
      grant_idx = next_pick[3:0];
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= 4'd15;
      sel       <= 4'd0;
      gnt       <= 16'd0;
      out_data  <= '0;
      out_valid <= 1'b0;
    end else begin
      if (release_item) begin
        ptr <= sel;
      end
      if (grant_en) begin
        state     <= HOLD;
        sel       <= grant_idx;
        gnt       <= 16'h0001 << grant_idx;
        out_data  <= lane[grant_idx];
        out_valid <= 1'b1;
      end else if (release_item) begin
        state     <= IDLE;
        gnt       <= 16'd0;
        out_valid <= 1'b0;
      end
      // HOLD without out_ready: everything frozen; IDLE without requests:
      // sel keeps its last value.
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rr_mux16_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rr_mux16_arbiter
//  Purpose  : Directed self-checking bench for rr_mux16_arbiter. Each task
//             drives one scenario and compares outputs against hand-computed
//             values. Prints one summary line at the end.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_rr_mux16_arbiter;

  localparam int W = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic [15:0]     req;
  logic [16*W-1:0] inp;
  logic            out_ready;
  logic [15:0]     gnt;
  logic [3:0]      sel;
  logic [W-1:0]    out_data;
  logic            out_valid;

  int passed = 0;
  int total  = 0;

  rr_mux16_arbiter #(.W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .inp       (inp),
    .out_ready (out_ready),
    .gnt       (gnt),
    .sel       (sel),
    .out_data  (out_data),
    .out_valid (out_valid)
  );

  always #5 clk = ~clk;

  // Advance one rising edge, then sample 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_lane(input int i, input logic [W-1:0] v);
    inp[i*W +: W] = v;
  endtask

  task automatic base_lanes();
    for (int i = 0; i < 16; i++) begin
      inp[i*W +: W] = 8'h10 + 8'(i);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; req = 16'd0; out_ready = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    base_lanes();
    rst = 1'b1; req = 16'hFFFF; out_ready = 1'b1;
    for (int e = 0; e < 2; e++) begin
      tick();
      total++; if (gnt !== 16'd0) $display("FAIL reset_gnt[%0d]: got %h want 0000", e, gnt); else passed++;
      total++; if (sel !== 4'd0) $display("FAIL reset_sel[%0d]: got %0d want 0", e, sel); else passed++;
      total++; if (out_valid !== 1'b0) $display("FAIL reset_valid[%0d]: got %b want 0", e, out_valid); else passed++;
      total++; if (out_data !== 8'h00) $display("FAIL reset_data[%0d]: got %h want 00", e, out_data); else passed++;
    end
    rst = 1'b0;
    tick();
    total++; if (gnt !== 16'h0001) $display("FAIL first_gnt: got %h want 0001", gnt); else passed++;
    total++; if (sel !== 4'd0) $display("FAIL first_sel: got %0d want 0", sel); else passed++;
    total++; if (out_valid !== 1'b1) $display("FAIL first_valid: got %b want 1", out_valid); else passed++;
    total++; if (out_data !== 8'h10) $display("FAIL first_data: got %h want 10", out_data); else passed++;
    req = 16'd0;
    tick();
    total++; if (out_valid !== 1'b0) $display("FAIL first_release: got %b want 0", out_valid); else passed++;
  endtask

  task automatic test_single();
    set_lane(5, 8'hA5);
    req = 16'h0020; out_ready = 1'b1;
    tick();
    total++; if (gnt !== 16'h0020) $display("FAIL single_gnt: got %h want 0020", gnt); else passed++;
    total++; if (sel !== 4'd5) $display("FAIL single_sel: got %0d want 5", sel); else passed++;
    total++; if (out_data !== 8'hA5) $display("FAIL single_data: got %h want a5", out_data); else passed++;
    total++; if (out_valid !== 1'b1) $display("FAIL single_valid: got %b want 1", out_valid); else passed++;
    tick();
    total++; if (out_valid !== 1'b0) $display("FAIL single_release_valid: got %b want 0", out_valid); else passed++;
    total++; if (gnt !== 16'd0) $display("FAIL single_release_gnt: got %h want 0000", gnt); else passed++;
    req = 16'd0;
    tick();
    total++; if (sel !== 4'd5) $display("FAIL idle_sel_hold: got %0d want 5", sel); else passed++;
    total++; if (out_valid !== 1'b0) $display("FAIL idle_valid: got %b want 0", out_valid); else passed++;
    base_lanes();
  endtask

  task automatic test_alternate();
`ifdef ARB_B2B_EN
    localparam int N = 4;
    logic        exp_v [N] = '{1'b1, 1'b1, 1'b1, 1'b1};
    logic [3:0]  exp_s [N] = '{4'd0, 4'd15, 4'd0, 4'd15};
`else
    localparam int N = 7;
    logic        exp_v [N] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [3:0]  exp_s [N] = '{4'd0, 4'd0, 4'd15, 4'd15, 4'd0, 4'd0, 4'd15};
`endif
    logic [15:0] exp_g;
    do_reset();
    req = 16'h8001; out_ready = 1'b1;
    for (int k = 0; k < N; k++) begin
      tick();
      exp_g = exp_v[k] ? (16'h0001 << exp_s[k]) : 16'd0;
      total++; if (out_valid !== exp_v[k]) $display("FAIL alt_valid[%0d]: got %b want %b", k, out_valid, exp_v[k]); else passed++;
      total++; if (sel !== exp_s[k]) $display("FAIL alt_sel[%0d]: got %0d want %0d", k, sel, exp_s[k]); else passed++;
      total++; if (gnt !== exp_g) $display("FAIL alt_gnt[%0d]: got %h want %h", k, gnt, exp_g); else passed++;
    end
    req = 16'd0;
    tick();
    total++; if (out_valid !== 1'b0) $display("FAIL alt_end_valid: got %b want 0", out_valid); else passed++;
  endtask

  task automatic test_hold();
    set_lane(3, 8'h3C);
    set_lane(8, 8'h88);
    req = 16'h0008; out_ready = 1'b0;
    tick();
    total++; if (sel !== 4'd3) $display("FAIL hold_grant_sel: got %0d want 3", sel); else passed++;
    set_lane(3, 8'hFF);
    req = 16'h0100;
    for (int c = 0; c < 4; c++) begin
      tick();
      total++; if (sel !== 4'd3) $display("FAIL hold_sel[%0d]: got %0d want 3", c, sel); else passed++;
      total++; if (out_data !== 8'h3C) $display("FAIL hold_data[%0d]: got %h want 3c", c, out_data); else passed++;
      total++; if (gnt !== 16'h0008) $display("FAIL hold_gnt[%0d]: got %h want 0008", c, gnt); else passed++;
      total++; if (out_valid !== 1'b1) $display("FAIL hold_valid[%0d]: got %b want 1", c, out_valid); else passed++;
    end
    out_ready = 1'b1;
    tick();
`ifndef ARB_B2B_EN
    total++; if (out_valid !== 1'b0) $display("FAIL hold_bubble: got %b want 0", out_valid); else passed++;
    tick();
`endif
    total++; if (sel !== 4'd8) $display("FAIL hold_next_sel: got %0d want 8", sel); else passed++;
    total++; if (out_data !== 8'h88) $display("FAIL hold_next_data: got %h want 88", out_data); else passed++;
    total++; if (out_valid !== 1'b1) $display("FAIL hold_next_valid: got %b want 1", out_valid); else passed++;
    req = 16'd0;
    tick();
    total++; if (out_valid !== 1'b0) $display("FAIL hold_end_valid: got %b want 0", out_valid); else passed++;
    base_lanes();
  endtask

  task automatic test_wrap();
    req = 16'h8000; out_ready = 1'b0;
    tick();
    total++; if (sel !== 4'd15) $display("FAIL wrap_sel15: got %0d want 15", sel); else passed++;
    req = 16'h0003; out_ready = 1'b1;
    tick();
`ifndef ARB_B2B_EN
    total++; if (out_valid !== 1'b0) $display("FAIL wrap_bubble0: got %b want 0", out_valid); else passed++;
    tick();
`endif
    total++; if (sel !== 4'd0) $display("FAIL wrap_sel0: got %0d want 0", sel); else passed++;
    total++; if (out_data !== 8'h10) $display("FAIL wrap_data0: got %h want 10", out_data); else passed++;
    tick();
`ifndef ARB_B2B_EN
    total++; if (out_valid !== 1'b0) $display("FAIL wrap_bubble1: got %b want 0", out_valid); else passed++;
    tick();
`endif
    total++; if (sel !== 4'd1) $display("FAIL wrap_sel1: got %0d want 1", sel); else passed++;
    total++; if (out_data !== 8'h11) $display("FAIL wrap_data1: got %h want 11", out_data); else passed++;
    req = 16'd0;
    tick();
  endtask

  task automatic test_reset_in_hold();
    req = 16'h0004; out_ready = 1'b0;
    tick();
    total++; if (sel !== 4'd2) $display("FAIL rsthold_sel: got %0d want 2", sel); else passed++;
    rst = 1'b1;
    tick();
    total++; if (out_valid !== 1'b0) $display("FAIL rsthold_valid: got %b want 0", out_valid); else passed++;
    total++; if (gnt !== 16'd0) $display("FAIL rsthold_gnt: got %h want 0000", gnt); else passed++;
    total++; if (out_data !== 8'h00) $display("FAIL rsthold_data: got %h want 00", out_data); else passed++;
    rst = 1'b0; req = 16'h8001;
    tick();
    total++; if (sel !== 4'd0) $display("FAIL rsthold_next_sel: got %0d want 0", sel); else passed++;
    total++; if (gnt !== 16'h0001) $display("FAIL rsthold_next_gnt: got %h want 0001", gnt); else passed++;
  endtask

  initial begin
    rst = 1'b1; req = 16'd0; out_ready = 1'b0; inp = '0;
    test_reset();
    test_single();
    test_alternate();
    test_hold();
    test_wrap();
    test_reset_in_hold();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rr_mux16_arbiter.md
Name: rr_mux16_arbiter

Overview:
Round-robin arbiter and sequencer for a shared 16:1 W-bit mux datapath. Sixteen requesters each present a W-bit lane. The block picks one requester, drives the mux select, and registers the selected lane. It then holds that lane on a valid/ready output port until the downstream consumer accepts it. It sits in front of the 16:1 mux, between multiple sources and a single-consumer datapath.

Parameters:
W, 8, data width of each input lane and of out_data.

Ports:
clk  input  1  system clock; all state changes on the rising edge.
rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
req  input  16  request lines; bit i high means requester i has data on lane i.
inp  input  16*W  flattened lanes; lane i = inp[i*W +: W].
out_ready  input  1  downstream accepts out_data when high together with out_valid.
gnt  output  16  one-hot grant; all zeros when nothing is granted.
sel  output  4  mux select, equal to the index of the granted requester.
out_data  output  W  registered copy of the granted lane.
out_valid  output  1  out_data holds an unaccepted item.

Behaviour:
- Reset (rst=1 at an edge), regardless of state or other inputs:
  - outputs: gnt=0, sel=0, out_data=0, out_valid=0
  - internal last-served pointer ptr=15, so the first search starts at index 0
  - state=IDLE
- State machine, two states:
  - IDLE: out_valid=0, gnt=0.
  - HOLD: out_valid=1; gnt is one-hot at bit sel.
- IDLE -> HOLD, at an edge with req != 0:
  - winner = first index with req set, scanning ptr+1, ptr+2, ... mod 16 (wrap-around 15 -> 0).
  - Same edge loads sel<=winner, gnt<=1<<winner, out_data<=lane[winner], out_valid<=1.
  - Latency: one edge from req sampled high to gnt/out_valid visible.
- IDLE with req=0: remain in IDLE; sel keeps its last value.
- HOLD with out_ready=0: sel, gnt and out_data are frozen. Changes on req and inp are ignored. A requester dropping req does not revoke its grant.
- HOLD with out_ready=1 (handshake edge): ptr<=sel, out_valid<=0, gnt<=0, state<=IDLE. This inserts one bubble cycle before the next grant (base build).
- The granted requester is not re-selected while any other req bit is set, because the scan starts at ptr+1. Starvation-free: worst-case wait is 15 grants.
- A requester is served again only if its req is still high when scanned.
- Reset asserted while in HOLD drops the item; out_valid falls on that edge and no handshake is counted.
- Simultaneous requests are resolved only by scan order. There is no fixed priority except relative to ptr.

Optional Feature:
Macro ARB_B2B_EN.
- Defined: back-to-back grants. On a handshake edge, if (req with bit sel masked) != 0, the block performs the next scan from ptr'=sel in the same edge and stays in HOLD. It loads the new sel/gnt/out_data, and out_valid stays 1. This sustains one item per cycle under continuous requests. If no other request is pending, it goes to IDLE as in the base build. The just-served requester is excluded from same-edge re-grant.
- Not defined: every handshake returns to IDLE for one cycle (maximum throughput one item per 2 cycles).

Test Plan:
1. rst=1 for 2 edges with req=16'hFFFF, out_ready=1 -> gnt=0, sel=0, out_valid=0, out_data=0 throughout. After rst falls, the first grant is index 0.
2. req=16'h0020, lane5=8'hA5, out_ready=1 -> after one edge: gnt=16'h0020, sel=5, out_data=8'hA5, out_valid=1. Next edge: out_valid=0 (base build).
3. req=16'h8001 held, out_ready=1 -> sel sequence 0,15,0,15 on successive grants. Base build: one idle cycle between grants. ARB_B2B_EN: out_valid stays high continuously.
4. Grant lane 3 (data 8'h3C) with out_ready=0 for 4 cycles, changing lane3 to 8'hFF and req to 16'h0100 meanwhile -> sel=3 and out_data=8'h3C stable. On out_ready=1, handshake, then the next grant is index 8.
5. Serve index 15, then req=16'h0003 -> grants 0 then 1 (wrap-around of the scan).
6. rst=1 while in HOLD with out_ready=0 -> out_valid=0, gnt=0 the following cycle. ptr resets, so req=16'h8001 next grants index 0.
